// File: rtl/tb_timer_pkg.sv
// Shared register map, control bit positions and FSM encoding for the timer/interrupt block.
package tb_timer_pkg;

  localparam int unsigned NUM_REGS   = 5;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_PERIOD = 1;
  localparam int unsigned REG_COUNT  = 2;
  localparam int unsigned REG_EVENTS = 3;
  localparam int unsigned REG_MISSED = 4;

  localparam int unsigned EN_BIT     = 0;
  localparam int unsigned CLR_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/tb_timer_down_counter.sv
// Loadable down-counter: emits a one-cycle expiry tick at COUNT==1 and reloads PERIOD.
module tb_timer_down_counter #(
  parameter int unsigned CNT_W      = 16,
  parameter logic [15:0] DEF_PERIOD = 16'd100
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             tick_c
);

  // A load (period write or clear) restarts the period, so it masks the tick.
  assign tick_c = en && (period != '0) && (count == CNT_W'(1)) && !load;

  // Count down while enabled with a non-zero period; hold otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= CNT_W'(DEF_PERIOD);
    end else if (load) begin
      count <= load_val;
    end else if (tick_c) begin
      count <= period;
    end else if (en && (period != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/tb_timer_intc.sv
// Port-mapped periodic timer with a pending/ack interrupt handshake for the processor.
module tb_timer_intc
  import tb_timer_pkg::*;
#(
  parameter logic [15:0] PORT_BASE  = 16'h0010,
  parameter logic [15:0] DEF_PERIOD = 16'd100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PORT_ID,
  input  logic [15:0] OUT_PORT,
  input  logic        WRITE_STROBE,
  input  logic        READ_STROBE,
  input  logic        INTERRUPT_ACK,
  output logic [15:0] IN_PORT,
  output logic        INTERRUPT
);

  logic [15:0]      offset_c;
  logic             hit_c;
  logic             wr_ctrl_c;
  logic             wr_period_c;
  logic             clr_c;
  logic             load_c;
  logic [CNT_W-1:0] load_val_c;
  logic             tick_c;
  logic             ev_inc_c;
  logic             miss_inc_c;
  logic             unused_rd_c;

  logic             en_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] events_q;
  logic [CNT_W-1:0] missed_q;
  state_t           state_q;
  state_t           state_d;

  // Reads are side-effect free; the strobe only qualifies the processor's sampling.
  assign unused_rd_c = READ_STROBE;

  // Address decode relative to the block base.
  assign offset_c    = PORT_ID - PORT_BASE;
  assign hit_c       = (PORT_ID >= PORT_BASE) && (offset_c < 16'(NUM_REGS));
  assign wr_ctrl_c   = WRITE_STROBE && hit_c && (offset_c == 16'(REG_CTRL));
  assign wr_period_c = WRITE_STROBE && hit_c && (offset_c == 16'(REG_PERIOD));
  assign clr_c       = wr_ctrl_c && OUT_PORT[CLR_BIT];
  assign load_c      = wr_period_c || clr_c;
  assign load_val_c  = wr_period_c ? OUT_PORT[CNT_W-1:0] : period_q;

  tb_timer_down_counter #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD)
  ) u_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (en_q),
    .load     (load_c),
    .load_val (load_val_c),
    .period   (period_q),
    .count    (count_q),
    .tick_c   (tick_c)
  );

  // Control/period registers and the event/missed counters (clear wins over increment).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q     <= 1'b0;
      period_q <= CNT_W'(DEF_PERIOD);
      events_q <= '0;
      missed_q <= '0;
    end else begin
      if (wr_ctrl_c) begin
        en_q <= OUT_PORT[EN_BIT];
      end
      if (wr_period_c) begin
        period_q <= OUT_PORT[CNT_W-1:0];
      end
      if (clr_c) begin
        events_q <= '0;
        missed_q <= '0;
      end else begin
        if (ev_inc_c) begin
          events_q <= events_q + CNT_W'(1);
        end
        if (miss_inc_c && (missed_q != '1)) begin
          missed_q <= missed_q + CNT_W'(1);
        end
      end
    end
  end

  // FSM state register; INTERRUPT is registered straight from the next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      INTERRUPT <= 1'b0;
    end else begin
      state_q   <= state_d;
      INTERRUPT <= (state_d == PEND);
    end
  end

  // Next-state and counter-increment decisions.
  always_comb begin
    state_d    = state_q;
    ev_inc_c   = 1'b0;
    miss_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = tick_c ? PEND : RUN;
        end
      end
      RUN: begin
        if (tick_c) begin
          state_d = PEND;
        end else if (!en_q) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (INTERRUPT_ACK) begin
          ev_inc_c = 1'b1;
          if (!tick_c) begin
            state_d = en_q ? RUN : IDLE;
          end
        end else if (tick_c) begin
          miss_inc_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    IN_PORT = 16'h0000;
    if (hit_c) begin
      case (offset_c)
        16'(REG_CTRL):   IN_PORT = 16'(en_q);
        16'(REG_PERIOD): IN_PORT = 16'(period_q);
        16'(REG_COUNT):  IN_PORT = 16'(count_q);
        16'(REG_EVENTS): IN_PORT = 16'(events_q);
        16'(REG_MISSED): IN_PORT = 16'(missed_q);
        default:         IN_PORT = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/tb_timer_intc.md
Name: tb_timer_intc

Overview:
- Port-mapped periodic timer and interrupt controller that sits directly upstream of tramelblaze_top.
- Counts CLK cycles and raises INTERRUPT on each period expiry.
- Holds INTERRUPT until the processor returns INTERRUPT_ACK.
- Exposes control and status registers on the processor's PORT_ID / OUT_PORT / IN_PORT bus, so firmware can program the period and read the event and missed-tick counters.

Parameters:
- PORT_BASE, 16'h0010, base port address; registers occupy PORT_BASE+0 .. PORT_BASE+4.
- DEF_PERIOD, 16'd100, PERIOD register value after reset.
- CNT_W, 16, width of every counter and register (must be at most 16).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PORT_ID  in  16  processor port address.
- OUT_PORT  in  16  processor write data.
- WRITE_STROBE  in  1  one-cycle write qualifier.
- READ_STROBE  in  1  one-cycle read qualifier.
- INTERRUPT_ACK  in  1  processor acknowledge, at least one cycle high.
- IN_PORT  out  16  read data to the processor.
- INTERRUPT  out  1  interrupt request to the processor, registered.

Behaviour:
- Register map:
  - +0 CTRL (R/W): bit0 EN, bit1 CLR (write-1 pulse, reads 0).
  - +1 PERIOD (R/W).
  - +2 COUNT (R): current down-counter value.
  - +3 EVENTS (R): acknowledged interrupts, wraps at 2^CNT_W.
  - +4 MISSED (R): expiries while pending, saturates at all-ones.
- Reset (async): EN=0, PERIOD=DEF_PERIOD, COUNT=DEF_PERIOD, EVENTS=0, MISSED=0, INTERRUPT=0, FSM=IDLE. IN_PORT follows the read mux, so it reads 0 unless PORT_ID selects a register.
- Writes are taken on the rising edge where WRITE_STROBE=1 and PORT_ID matches a register. Writes to COUNT, EVENTS, MISSED or unmapped ports are ignored.
- IN_PORT is a combinational mux of PORT_ID:
  - mapped address: register value, zero-extended to 16 bits;
  - unmapped address: 16'h0000.
  - It is valid in the same cycle as READ_STROBE; READ_STROBE has no side effects.
- Counter:
  - While EN=1 and PERIOD!=0, COUNT decrements by 1 each cycle.
  - When COUNT==1 it generates an expiry tick and reloads COUNT=PERIOD in the same edge.
  - An expiry occurs every PERIOD cycles.
- PERIOD=0: COUNT holds, no ticks are generated.
- A PERIOD write loads COUNT with the new value on the same edge, restarting the period.
- CTRL CLR=1: COUNT=PERIOD, EVENTS=0, MISSED=0. Pending INTERRUPT is not affected.
- EN 1->0: COUNT freezes. EN 0->1: counting resumes from the frozen value.
- FSM states:
  - IDLE: EN=0. Goes to RUN when EN is set.
  - RUN: EN=1, INTERRUPT=0. On expiry, goes to PEND and sets INTERRUPT=1 on the next edge, i.e. one cycle after the tick.
  - PEND: INTERRUPT=1.
    - INTERRUPT_ACK=1: clear INTERRUPT, increment EVENTS, go to RUN (or IDLE if EN=0).
    - Expiry while pending and no ack: increment MISSED (saturating), INTERRUPT stays 1.
    - Expiry and ack in the same cycle: EVENTS increments, MISSED does not, stay in PEND with INTERRUPT=1 for the new request.
- EN cleared while in PEND: INTERRUPT is held until ack, then FSM goes to IDLE.
- INTERRUPT_ACK in IDLE or RUN is ignored. A multi-cycle ack counts as one event, because PEND is left on the first cycle.

Decomposition:
- Package tb_timer_pkg holds:
  - register offsets REG_CTRL=0, REG_PERIOD=1, REG_COUNT=2, REG_EVENTS=3, REG_MISSED=4;
  - CTRL bit indices EN_BIT=0, CLR_BIT=1;
  - FSM state encoding {IDLE, RUN, PEND}.
- One natural sub-module, tb_timer_down_counter: the loadable down-counter with tick output.
- The FSM, register file and read mux stay in the top module.

Test Plan:
1. Reset, then read ports PORT_BASE+0..+4 -> 0, 100, 100, 0, 0. INTERRUPT=0.
2. Write PERIOD=10, CTRL=1. Bench acks each interrupt within 3 cycles -> INTERRUPT rises every 10 cycles; after 5 acks EVENTS=5, MISSED=0.
3. PERIOD=10, never ack for 55 cycles -> INTERRUPT stays 1, MISSED=4, EVENTS=0. Then ack -> INTERRUPT=0, EVENTS=1.
4. Ack asserted in exactly the expiry cycle -> EVENTS increments, MISSED unchanged, INTERRUPT remains 1.
5. Assert RESET mid-count with INTERRUPT=1 -> INTERRUPT=0 immediately (async); all registers back to reset values.
6. PERIOD=0 with EN=1 for 200 cycles -> no interrupt, COUNT=0. A read of unmapped PORT_BASE+7 returns 16'h0000. CTRL=3 (EN and CLR) -> EVENTS=MISSED=0, COUNT=PERIOD.
